// File: rtl/pe_pkg.sv
// Shared definitions for the reversible PE error-logging path: source codes,
// log entry layout and default sizing.
package pe_pkg;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int TS_WIDTH_DEF   = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  // Source field of a log entry: bit 0 = multiplier check, bit 1 = adder check.
  localparam logic [1:0] ERR_SRC_MULT = 2'b01;
  localparam logic [1:0] ERR_SRC_ADD  = 2'b10;
  localparam logic [1:0] ERR_SRC_BOTH = 2'b11;

  // One log entry as seen by the host: which check failed and when.
  typedef struct packed {
    logic [1:0]              src;
    logic [TS_WIDTH_DEF-1:0] stamp;
  } err_entry_t;

  // Fold the two error flags into the entry source field.
  function automatic logic [1:0] err_src(input logic mult_err, input logic add_err);
    logic [1:0] src;
    src = 2'b00;
    if (mult_err) src = src | ERR_SRC_MULT;
    if (add_err)  src = src | ERR_SRC_ADD;
    return src;
  endfunction

endpackage

// File: rtl/pe_err_fifo.sv
// Small synchronous FIFO for error log entries. Pointers carry one extra
// wrap bit so full/empty come from a plain compare. Reads are registered:
// a pop at edge E presents the entry (with rd_valid) for the cycle after E.
module pe_err_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop on an empty FIFO is ignored; a push while full is only taken when
  // a pop frees the slot in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Entry storage; no reset so it can map onto RAM. When full with a
  // simultaneous push/pop the read sees the old (oldest) entry first.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointers and registered read port; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + (AW+1)'(1);
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/pe_err_logger.sv
// Error logger behind the reversible PE: synchronizes the error flags,
// timestamps each error cycle within a run, queues one entry per error
// cycle and keeps per-source saturating counters for the host to read.
module pe_err_logger
  import pe_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_start,
  input  logic                  run_active,
  input  logic                  err1,
  input  logic                  err2,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic [TS_WIDTH+1:0]   rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  err1_cnt,
  output logic [CNT_WIDTH-1:0]  err2_cnt
);

  logic                err1_s1, err1_s2;
  logic                err2_s1, err2_s2;
  logic                act_s1, act_s2;
  logic [TS_WIDTH-1:0] ts, ts_s1, ts_s2;
  logic                evt;
  logic [1:0]          evt_src;
  logic                pop_ok;
  logic                drop;

  // Two-flop synchronizers; the timestamp rides along so each flag keeps
  // the stamp of the edge where it was first captured. run_start flushes
  // anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err1_s1 <= 1'b0;
      err1_s2 <= 1'b0;
      err2_s1 <= 1'b0;
      err2_s2 <= 1'b0;
      act_s1  <= 1'b0;
      act_s2  <= 1'b0;
      ts_s1   <= '0;
      ts_s2   <= '0;
    end else if (run_start) begin
      err1_s1 <= 1'b0;
      err1_s2 <= 1'b0;
      err2_s1 <= 1'b0;
      err2_s2 <= 1'b0;
      act_s1  <= 1'b0;
      act_s2  <= 1'b0;
      ts_s1   <= '0;
      ts_s2   <= '0;
    end else begin
      err1_s1 <= err1;
      err1_s2 <= err1_s1;
      err2_s1 <= err2;
      err2_s2 <= err2_s1;
      act_s1  <= run_active;
      act_s2  <= act_s1;
      ts_s1   <= ts;
      ts_s2   <= ts_s1;
    end
  end

  // Per-run cycle timestamp: restarts on run_start, counts while active,
  // sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else if (run_start) begin
      ts <= '0;
    end else if (run_active && (ts != {TS_WIDTH{1'b1}})) begin
      ts <= ts + TS_WIDTH'(1);
    end
  end

  // Every synchronized error cycle inside a run is one event; both flags
  // in the same cycle share a single entry.
  assign evt     = act_s2 && (err1_s2 || err2_s2);
  assign evt_src = err_src(err1_s2, err2_s2);
  assign pop_ok  = rd_req && !empty;
  assign drop    = evt && full && !pop_ok;

  // Saturating per-source counters; they count dropped events too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err1_cnt <= '0;
      err2_cnt <= '0;
    end else if (run_start) begin
      err1_cnt <= '0;
      err2_cnt <= '0;
    end else begin
      if (evt && err1_s2 && (err1_cnt != {CNT_WIDTH{1'b1}})) begin
        err1_cnt <= err1_cnt + CNT_WIDTH'(1);
      end
      if (evt && err2_s2 && (err2_cnt != {CNT_WIDTH{1'b1}})) begin
        err2_cnt <= err2_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Sticky overflow: remembers any entry lost to a full log until the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (run_start) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  pe_err_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TS_WIDTH + 2)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (run_start),
    .push     (evt),
    .pop      (rd_req),
    .wr_data  ({evt_src, ts_s2}),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full)
  );

endmodule
